// File: rtl/ncl_count_sampler.sv
// Clocked consumer for a chain of dual-rail NCL counter digits: acknowledges each digit,
// assembles binary count words, hands them off valid/ready and checks rail and sequence sanity.
module ncl_count_sampler #(
  parameter int unsigned DIGITS      = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  init,
  input  logic [2*DIGITS-1:0]   sum,
  output logic [DIGITS-1:0]     sum_comp,
  output logic [DIGITS-1:0]     count,
  output logic                  count_valid,
  input  logic                  count_ready,
  output logic                  err_illegal,
  output logic                  err_seq,
  output logic [7:0]            seq_err_cnt,
  input  logic                  clear_err
);

  typedef enum logic {StWaitData, StWaitNull} digit_st_e;

  logic [2*DIGITS-1:0] sync_q [SYNC_STAGES];
  logic [2*DIGITS-1:0] s;

  digit_st_e           st_q [DIGITS];
  digit_st_e           st_d [DIGITS];
  logic [DIGITS-1:0]   have_q, have_d;
  logic [DIGITS-1:0]   hold_q, hold_d;
  logic [DIGITS-1:0]   count_q;
  logic                count_valid_q;
  logic [DIGITS-1:0]   prev_q;
  logic                first_q;
  logic                err_illegal_q, err_seq_q;
  logic [7:0]          seq_err_cnt_q;

  logic [1:0]          rails;
  logic                illegal_evt;
  logic                load;
  logic                seq_evt;
  logic [DIGITS-1:0]   prev_inc;

  always_ff @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= sum;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s        = sync_q[SYNC_STAGES-1];
  assign load     = (&have_q) && (!count_valid_q || count_ready);
  assign prev_inc = prev_q + 1'b1;
  assign seq_evt  = load && !first_q && (hold_q != prev_inc);

  // A digit that already holds a bit for the pending word stays in StWaitData with
  // comp low, which stalls the ring until the word is handed off.
  always_comb begin
    have_d      = have_q;
    hold_d      = hold_q;
    illegal_evt = 1'b0;
    rails       = 2'b00;
    for (int i = 0; i < DIGITS; i++) begin
      st_d[i] = st_q[i];
      rails   = s[2*i +: 2];
      if (rails == 2'b11) begin
        illegal_evt = 1'b1;
      end else begin
        unique case (st_q[i])
          StWaitData: begin
            if (rails != 2'b00 && !have_q[i]) begin
              hold_d[i] = rails[1];
              have_d[i] = 1'b1;
              st_d[i]   = StWaitNull;
            end
          end
          StWaitNull: begin
            if (rails == 2'b00) st_d[i] = StWaitData;
          end
        endcase
      end
    end
    if (load) have_d = '0;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < DIGITS; i++) st_q[i] <= StWaitData;
      have_q        <= '0;
      hold_q        <= '0;
      count_q       <= '0;
      count_valid_q <= 1'b0;
      prev_q        <= '0;
      first_q       <= 1'b1;
    end else begin
      for (int i = 0; i < DIGITS; i++) st_q[i] <= st_d[i];
      have_q <= have_d;
      hold_q <= hold_d;
      if (load) begin
        count_q       <= hold_q;
        count_valid_q <= 1'b1;
        prev_q        <= hold_q;
        first_q       <= 1'b0;
      end else if (count_valid_q && count_ready) begin
        count_valid_q <= 1'b0;
      end
    end
  end

  // An error event in the same cycle as clear_err takes precedence over the clear.
  always_ff @(posedge clk) begin
    if (init) begin
      err_illegal_q <= 1'b0;
      err_seq_q     <= 1'b0;
      seq_err_cnt_q <= '0;
    end else begin
      if (illegal_evt)    err_illegal_q <= 1'b1;
      else if (clear_err) err_illegal_q <= 1'b0;

      if (seq_evt) begin
        err_seq_q <= 1'b1;
        if (clear_err)                   seq_err_cnt_q <= 8'd1;
        else if (seq_err_cnt_q != 8'hff) seq_err_cnt_q <= seq_err_cnt_q + 8'd1;
      end else if (clear_err) begin
        err_seq_q     <= 1'b0;
        seq_err_cnt_q <= '0;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < DIGITS; i++) sum_comp[i] = (st_q[i] == StWaitNull);
  end

  assign count       = count_q;
  assign count_valid = count_valid_q;
  assign err_illegal = err_illegal_q;
  assign err_seq     = err_seq_q;
  assign seq_err_cnt = seq_err_cnt_q;

endmodule

// File: tb/tb_ncl_count_sampler.sv
// Directed bench for ncl_count_sampler with DIGITS=32, SYNC_STAGES=2.
module tb_ncl_count_sampler;

  localparam int unsigned D = 32;

  logic          clk = 1'b0;
  logic          init;
  logic [2*D-1:0] sum;
  logic [D-1:0]  sum_comp;
  logic [D-1:0]  count;
  logic          count_valid;
  logic          count_ready;
  logic          err_illegal;
  logic          err_seq;
  logic [7:0]    seq_err_cnt;
  logic          clear_err;

  int n_cmp = 0;
  int n_err = 0;

  ncl_count_sampler #(.DIGITS(D), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .init       (init),
    .sum        (sum),
    .sum_comp   (sum_comp),
    .count      (count),
    .count_valid(count_valid),
    .count_ready(count_ready),
    .err_illegal(err_illegal),
    .err_seq    (err_seq),
    .seq_err_cnt(seq_err_cnt),
    .clear_err  (clear_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [2*D-1:0] enc(input logic [D-1:0] v);
    logic [2*D-1:0] r;
    for (int i = 0; i < D; i++) r[2*i +: 2] = v[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

  task automatic wait_comp(input string tag, input logic [D-1:0] exp);
    int k;
    k = 0;
    while (sum_comp !== exp && k < 50) begin
      tick(1);
      k++;
    end
    check_eq(tag, sum_comp, exp);
  endtask

  task automatic send_word(input logic [D-1:0] v);
    sum = enc(v);
    wait_comp("ack_data", '1);
    sum = '0;
    wait_comp("ack_null", '0);
  endtask

  task automatic reinit();
    init = 1'b1;
    tick(1);
    init = 1'b0;
  endtask

  initial begin
    init        = 1'b1;
    sum         = {$urandom, $urandom};
    count_ready = 1'b0;
    clear_err   = 1'b0;

    // Reset
    tick(3);
    check_eq("rst_comp", sum_comp, 0);
    check_eq("rst_count", count, 0);
    check_eq("rst_valid", count_valid, 0);
    check_eq("rst_errs", {err_illegal, err_seq, seq_err_cnt}, 0);
    init = 1'b0;
    sum  = '0;
    tick(5);
    check_eq("null_comp", sum_comp, 0);
    check_eq("null_valid", count_valid, 0);

    // Single wavefront: comp after 3 edges, word one edge later
    sum = enc(32'h0000_0005);
    tick(2);
    check_eq("sw_comp_early", sum_comp, 0);
    tick(1);
    check_eq("sw_comp", sum_comp, 32'hffff_ffff);
    check_eq("sw_valid_early", count_valid, 0);
    tick(1);
    check_eq("sw_valid", count_valid, 1);
    check_eq("sw_count", count, 32'h5);
    sum = '0;
    tick(2);
    check_eq("sw_null_early", sum_comp, 32'hffff_ffff);
    tick(1);
    check_eq("sw_null", sum_comp, 0);
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
    check_eq("sw_consumed", count_valid, 0);

    // Skewed digit 31 with ready low
    sum = enc(32'h0000_0006);
    sum[63:62] = 2'b00;
    tick(40);
    check_eq("skew_comp", sum_comp, 32'h7fff_ffff);
    check_eq("skew_valid", count_valid, 0);
    sum[63:62] = 2'b01;
    tick(3);
    check_eq("skew_comp_all", sum_comp, 32'hffff_ffff);
    tick(1);
    check_eq("skew_valid2", count_valid, 1);
    check_eq("skew_count", count, 32'h6);
    sum = '0;
    tick(4);
    check_eq("skew_null", sum_comp, 0);
    // Word 7 fills the hold stage; word 8 must then stall
    sum = enc(32'h0000_0007);
    tick(4);
    check_eq("w7_comp", sum_comp, 32'hffff_ffff);
    check_eq("w7_count_stable", count, 32'h6);
    sum = '0;
    tick(4);
    check_eq("w7_null", sum_comp, 0);
    sum = enc(32'h0000_0008);
    tick(10);
    check_eq("w8_stall_comp", sum_comp, 0);
    check_eq("w8_stall_count", count, 32'h6);
    check_eq("w8_stall_valid", count_valid, 1);
    count_ready = 1'b1;
    tick(1);
    count_ready = 1'b0;
    check_eq("b2b_count", count, 32'h7);
    check_eq("b2b_valid", count_valid, 1);
    check_eq("b2b_comp", sum_comp, 0);
    tick(1);
    check_eq("w8_comp", sum_comp, 32'hffff_ffff);
    tick(1);
    check_eq("w8_hold_count", count, 32'h7);
    sum = '0;
    count_ready = 1'b1;
    tick(1);
    check_eq("w8_count", count, 32'h8);
    tick(5);
    check_eq("drain_valid", count_valid, 0);
    check_eq("drain_comp", sum_comp, 0);
    check_eq("inc_no_err", err_seq, 0);

    // Sequence and wrap
    reinit();
    send_word(32'hffff_fffe);
    send_word(32'hffff_ffff);
    send_word(32'h0000_0000);
    check_eq("wrap_err_seq", err_seq, 0);
    check_eq("wrap_count", count, 0);
    send_word(32'h0000_0002);
    check_eq("skip_err_seq", err_seq, 1);
    check_eq("skip_cnt", seq_err_cnt, 1);
    check_eq("skip_count", count, 32'h2);

    // Illegal rails on digit 7
    sum = '0;
    sum[15:14] = 2'b11;
    tick(5);
    check_eq("ill_flag", err_illegal, 1);
    check_eq("ill_comp7", sum_comp[7], 0);
    sum[15:14] = 2'b01;
    tick(2);
    check_eq("ill_comp7_wait", sum_comp[7], 0);
    tick(1);
    check_eq("ill_comp7_ack", sum_comp[7], 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("clr_all", {err_illegal, err_seq, seq_err_cnt}, 0);
    sum[15:14] = 2'b11;
    tick(2);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("clr_vs_ill", err_illegal, 1);
    sum[15:14] = 2'b00;
    tick(3);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("clr_ill", err_illegal, 0);

    // Saturation: 301 identical words give 300 sequence errors
    reinit();
    for (int w = 0; w < 301; w++) begin
      send_word(32'h0000_0000);
      if (w == 10) check_eq("sat_cnt10", seq_err_cnt, 10);
    end
    check_eq("sat_cnt", seq_err_cnt, 255);
    check_eq("sat_flag", err_seq, 1);
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    check_eq("sat_clear", {err_illegal, err_seq, seq_err_cnt}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
